// File: rtl/slow_down_counter_pkg.sv
// Shared defaults for the slow_down_counter decade counter.
package slow_down_counter_pkg;

  localparam int SDC_WIDTH   = 4;
  localparam int SDC_MODULUS = 10;

endpackage : slow_down_counter_pkg

// File: rtl/slow_down_counter.sv
// Enable-gated modulo counter, q runs 0..MODULUS-1 and wraps.
// Optional terminal-count strobe tc exists only when SLOW_DOWN_COUNTER_TC_EN is defined.
module slow_down_counter
  import slow_down_counter_pkg::*;
#(
  parameter int WIDTH   = SDC_WIDTH,
  parameter int MODULUS = SDC_MODULUS
) (
  input  logic             clk,
  input  logic             slowena,
  input  logic             reset,
  output logic [WIDTH-1:0] q
`ifdef SLOW_DOWN_COUNTER_TC_EN
  ,
  output logic             tc
`endif
);

  // The count must fit in q and needs at least two states to be meaningful.
  if (MODULUS < 2 || MODULUS > (1 << WIDTH)) begin : g_bad_params
    $error("slow_down_counter: MODULUS must lie in 2..2**WIDTH");
  end

  localparam logic [WIDTH-1:0] LAST = WIDTH'(MODULUS - 1);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  // Using >= rather than == also recovers from any out-of-range value on the next enabled edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q <= '0;
    end else if (slowena) begin
      q <= (q >= LAST) ? '0 : q + WIDTH'(1);
    end
  end

`ifdef SLOW_DOWN_COUNTER_TC_EN
  assign tc = slowena & (q == LAST);
`endif

endmodule : slow_down_counter

// File: tb/tb_slow_down_counter.sv
// Self-checking bench for slow_down_counter: default (mod 10) and MODULUS=6 instances
// compared against a modular-arithmetic reference model; checks tc when SLOW_DOWN_COUNTER_TC_EN is defined.
module tb_slow_down_counter;

  logic       clk = 1'b0;
  logic       reset;
  logic       slowena;
  logic [3:0] q;
  logic [3:0] q6;
`ifdef SLOW_DOWN_COUNTER_TC_EN
  logic       tc;
  logic       tc6;
`endif

  int vectors     = 0;
  int miscompares = 0;
  int exp_q       = 0;
  int exp_q6      = 0;

  always #5 clk = ~clk;

  slow_down_counter dut (
    .clk     (clk),
    .slowena (slowena),
    .reset   (reset),
    .q       (q)
`ifdef SLOW_DOWN_COUNTER_TC_EN
    ,
    .tc      (tc)
`endif
  );

  slow_down_counter #(.WIDTH(4), .MODULUS(6)) dut6 (
    .clk     (clk),
    .slowena (slowena),
    .reset   (reset),
    .q       (q6)
`ifdef SLOW_DOWN_COUNTER_TC_EN
    ,
    .tc      (tc6)
`endif
  );

  task automatic check(input string tag, input int observed, input int expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // One clock: drive enable at the falling edge, check tc, then check q after the rising edge.
  task automatic step(input logic en, input string tag);
    @(negedge clk);
    slowena = en;
    #1;
`ifdef SLOW_DOWN_COUNTER_TC_EN
    check({tag, "_tc"},  int'(tc),  int'(en && exp_q  == 9));
    check({tag, "_tc6"}, int'(tc6), int'(en && exp_q6 == 5));
`endif
    @(posedge clk);
    #1;
    if (en) begin
      exp_q  = (exp_q  + 1) % 10;
      exp_q6 = (exp_q6 + 1) % 6;
    end
    check({tag, "_q"},  int'(q),  exp_q);
    check({tag, "_q6"}, int'(q6), exp_q6);
  endtask

  // Assert reset between clock edges, confirm it acts at once and holds through an enabled edge.
  task automatic pulse_reset(input string tag);
    @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    exp_q  = 0;
    exp_q6 = 0;
    check({tag, "_async_q"},  int'(q),  0);
    check({tag, "_async_q6"}, int'(q6), 0);
    slowena = 1'b1;
    @(posedge clk);
    #1;
    check({tag, "_hold_q"},  int'(q),  0);
    check({tag, "_hold_q6"}, int'(q6), 0);
`ifdef SLOW_DOWN_COUNTER_TC_EN
    check({tag, "_hold_tc"}, int'(tc), 0);
`endif
    @(negedge clk);
    reset   = 1'b1;
    slowena = 1'b0;
  endtask

  initial begin
    // Reset low for the first 10 ns with the enable off.
    reset   = 1'b0;
    slowena = 1'b0;
    #3;
    check("rst_q", int'(q), 0);
    check("rst_q6", int'(q6), 0);
    #4;
    check("rst_edge_q", int'(q), 0);
    #3;
    reset = 1'b1;
    step(1'b0, "idle0");
    step(1'b0, "idle1");

    // First enabled edges after reset: 1, 2, 3.
    step(1'b1, "cnt1");
    step(1'b1, "cnt2");
    step(1'b1, "cnt3");
    step(1'b1, "cnt4");

    // Enable toggled 1,0,1,0 from 4: 5, 5, 6, 6.
    step(1'b1, "tog1");
    step(1'b0, "tog0");
    step(1'b1, "tog2");
    step(1'b0, "tog3");
    step(1'b1, "to7");
    check("at7", int'(q), 7);

    // Mid-cycle reset at 7, then the MODULUS=6 wrap sequence 1..5,0,1.
    pulse_reset("mid");
    for (int i = 0; i < 7; i++) step(1'b1, "seq");
    check("seq_q6_end", int'(q6), 1);

    // Run up to 9, hold there, then wrap.
    while (exp_q != 9) step(1'b1, "run");
    step(1'b0, "hold9");
    check("hold9_val", int'(q), 9);
    step(1'b1, "wrap");
    check("wrap_val", int'(q), 0);

    // Randomised enables with occasional asynchronous resets.
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(39) == 0) pulse_reset("rnd_rst");
      else step(1'($urandom_range(1)), "rnd");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_slow_down_counter

// File: doc/slow_down_counter.md
SLOW_DOWN_COUNTER -- requirements
Module: slow_down_counter

Interface
REQ-001 SHALL have parameter WIDTH, default 4: counter width in bits.
REQ-002 SHALL have parameter MODULUS, default 10: count cycle length; q runs 0..MODULUS-1.
REQ-003 SHALL have port clk, input, 1: single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1: reset, asynchronous, active-low; 0 = reset asserted.
REQ-005 SHALL have port slowena, input, 1: count enable; 1 = advance one step this cycle.
REQ-006 SHALL have port q, output, WIDTH: current count, registered.
REQ-007 SHALL have port tc, output, 1, present only when SLOW_DOWN_COUNTER_TC_EN is defined: terminal-count strobe.

Function
REQ-008 SHALL, on a rising clk edge with reset high and slowena=1, load q+1 when q<MODULUS-1.
REQ-009 SHALL, on a rising clk edge with reset high, slowena=1 and q=MODULUS-1, load 0 (wrap).
REQ-010 SHALL hold q unchanged on a rising edge when slowena=0, including at q=MODULUS-1.
REQ-011 SHALL, if q ever holds a value >= MODULUS, load 0 on the next enabled edge.
REQ-012 SHALL drive q directly from the state register: no combinational path from slowena to q.
REQ-013 SHALL, with TC enabled, drive tc = slowena AND (q==MODULUS-1), combinationally; tc is high in the cycle before the wrap.
REQ-014 SHALL sample slowena only at rising clk edges; glitches between edges are ignored.

Reset
REQ-015 SHALL force q to 0 immediately when reset goes low, regardless of clk.
REQ-016 SHALL hold q at 0 while reset is low, ignoring slowena.
REQ-017 SHALL, when reset is released, make the first rising edge with slowena=1 load q=1.
REQ-018 SHALL hold tc at 0 while reset is low (q=0, not terminal unless MODULUS=1).

Configuration
REQ-019 SHALL use macro SLOW_DOWN_COUNTER_TC_EN: when defined, port tc and its logic exist per REQ-013; when undefined, tc is absent and the port list is exactly clk, slowena, reset, q.
REQ-020 SHALL keep q behaviour identical with and without SLOW_DOWN_COUNTER_TC_EN.

Structure
REQ-021 SHALL place default constants SDC_WIDTH=4 and SDC_MODULUS=10 in shared package slow_down_counter_pkg; module parameters default to these.
REQ-022 SHALL fail elaboration if MODULUS<2 or MODULUS>2**WIDTH.
REQ-023 SHALL be implemented as a single flat module; no sub-module.

Verification
REQ-024 SHALL cover: reset low 10 ns with slowena=0, clk period 10 ns -> q=0000 during reset and after release while slowena=0.
REQ-025 SHALL cover: slowena=1 from reset value for 3 edges -> q=0001, 0010, 0011.
REQ-026 SHALL cover: slowena=1 from q=1001 -> next edge q=0000; with TC enabled, tc=1 only while q=1001.
REQ-027 SHALL cover: slowena toggled 1,0,1,0 starting at q=0100 -> q=0101, 0101, 0110, 0110.
REQ-028 SHALL cover: reset driven low mid-cycle at q=0111 -> q=0000 without waiting for a clk edge.
REQ-029 SHALL cover: MODULUS=6 instance, slowena=1 for 7 edges from 0 -> 1,2,3,4,5,0,1.
